// File: rtl/dht11_pkg.sv
// Shared types and ASCII constants for the DHT11 UART reporter.
package dht11_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, SEND} state_t;

  localparam logic [7:0] ASCII_H     = 8'h48;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int MSG_LEN_BASE = 11;
  localparam int MSG_LEN_FRAC = 15;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/dht11_dec2.sv
// Combinational byte-to-two-decimal-digit converter; values above 99 clamp to 99.
// Zero latency, no handshake.
module dht11_dec2 (
  input  logic [7:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] clamped;

  always_comb begin
    clamped = (value > 8'd99) ? 7'd99 : value[6:0];
    tens    = 4'(clamped / 7'd10);
    ones    = 4'(clamped % 7'd10);
  end

endmodule

// File: rtl/dht11_uart_reporter.sv
// Checksums DHT11 frames and streams "H:dd T:dd\r\n" (or "H:dd.f T:dd.f\r\n" with DHT11_FRAC_EN)
// to a UART over valid/ready; first byte two cycles after a trigger, tx_data held while stalled.
module dht11_uart_reporter
  import dht11_pkg::*;
#(
  parameter int REPORT_CYCLES = 100_000_000,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           hum_high,
  input  logic [7:0]           hum_low,
  input  logic [7:0]           tem_high,
  input  logic [7:0]           tem_low,
  input  logic [7:0]           checksum,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 csum_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

`ifdef DHT11_FRAC_EN
  localparam int MSG_LEN = MSG_LEN_FRAC;
`else
  localparam int MSG_LEN = MSG_LEN_BASE;
`endif
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);
  localparam int TIMER_W = (REPORT_CYCLES > 1) ? $clog2(REPORT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'((REPORT_CYCLES > 0) ? REPORT_CYCLES - 1 : 0);

  state_t               state, state_nxt;
  logic [39:0]          frame, snapshot;
  logic [TIMER_W-1:0]   timer;
  logic                 pending;
  logic [3:0]           idx;
  logic                 change, timer_exp, periodic, start, sum_ok;
  logic [7:0]           sum;
  logic [3:0]           hum_tens, hum_ones, tem_tens, tem_ones;
  logic [7:0]           msg_byte;

  assign frame     = {hum_high, hum_low, tem_high, tem_low, checksum};
  assign change    = (frame != snapshot) && (frame != 40'd0);
  assign timer_exp = (REPORT_CYCLES != 0) && (timer == TIMER_MAX);
  // A periodic re-report needs a frame to repeat; until one arrives the request stays pending.
  assign periodic  = (pending || timer_exp) && (snapshot != 40'd0);
  assign start     = (state == IDLE) && (change || periodic);
  assign sum       = snapshot[39:32] + snapshot[31:24] + snapshot[23:16] + snapshot[15:8];
  assign sum_ok    = (sum == snapshot[7:0]);

  dht11_dec2 u_hum_dec (.value(snapshot[39:32]), .tens(hum_tens), .ones(hum_ones));
  dht11_dec2 u_tem_dec (.value(snapshot[23:16]), .tens(tem_tens), .ones(tem_ones));

`ifdef DHT11_FRAC_EN
  logic [3:0] hum_frac, tem_frac;
  assign hum_frac = (snapshot[31:24] > 8'd9) ? 4'd9 : snapshot[27:24];
  assign tem_frac = (snapshot[15:8]  > 8'd9) ? 4'd9 : snapshot[11:8];
`endif

  always_comb begin
    msg_byte = 8'h00;
    case (idx)
`ifdef DHT11_FRAC_EN
      4'd0:  msg_byte = ASCII_H;
      4'd1:  msg_byte = ASCII_COLON;
      4'd2:  msg_byte = ascii_digit(hum_tens);
      4'd3:  msg_byte = ascii_digit(hum_ones);
      4'd4:  msg_byte = ASCII_DOT;
      4'd5:  msg_byte = ascii_digit(hum_frac);
      4'd6:  msg_byte = ASCII_SPACE;
      4'd7:  msg_byte = ASCII_T;
      4'd8:  msg_byte = ASCII_COLON;
      4'd9:  msg_byte = ascii_digit(tem_tens);
      4'd10: msg_byte = ascii_digit(tem_ones);
      4'd11: msg_byte = ASCII_DOT;
      4'd12: msg_byte = ascii_digit(tem_frac);
      4'd13: msg_byte = ASCII_CR;
      4'd14: msg_byte = ASCII_LF;
`else
      4'd0:  msg_byte = ASCII_H;
      4'd1:  msg_byte = ASCII_COLON;
      4'd2:  msg_byte = ascii_digit(hum_tens);
      4'd3:  msg_byte = ascii_digit(hum_ones);
      4'd4:  msg_byte = ASCII_SPACE;
      4'd5:  msg_byte = ASCII_T;
      4'd6:  msg_byte = ASCII_COLON;
      4'd7:  msg_byte = ascii_digit(tem_tens);
      4'd8:  msg_byte = ascii_digit(tem_ones);
      4'd9:  msg_byte = ASCII_CR;
      4'd10: msg_byte = ASCII_LF;
`endif
      default: msg_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    csum_err  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nxt = CHECK;
      CHECK: begin
        if (sum_ok) begin
          state_nxt = SEND;
        end else begin
          csum_err  = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = msg_byte;
        if (tx_ready && (idx == LAST_IDX)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot <= 40'd0;
      timer    <= '0;
      pending  <= 1'b0;
      idx      <= 4'd0;
      err_cnt  <= '0;
    end else begin
      // Periodic-only starts keep the old snapshot so F is not re-read.
      if (start && change) snapshot <= frame;

      if (start || timer_exp) timer <= '0;
      else                    timer <= timer + TIMER_W'(1);

      if (start)          pending <= 1'b0;
      else if (timer_exp) pending <= 1'b1;

      if (state == CHECK) begin
        if (sum_ok)                  idx     <= 4'd0;
        else if (err_cnt != '1)      err_cnt <= err_cnt + ERR_CNT_W'(1);
      end else if (state == SEND && tx_ready) begin
        idx <= idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// Directed bench: one reporter with the periodic timer disabled, one with a 50-cycle period.
module tb_dht11_uart_reporter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] hh, hl, th, tl, cs;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, busy, csum_err;
  logic [7:0] err_cnt;

  logic [7:0] p_hh, p_hl, p_th, p_tl, p_cs;
  logic [7:0] p_tx_data;
  logic       p_tx_valid, p_tx_ready, p_busy, p_csum_err;
  logic [7:0] p_err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dht11_uart_reporter #(.REPORT_CYCLES(0), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .hum_high(hh), .hum_low(hl), .tem_high(th), .tem_low(tl), .checksum(cs),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .csum_err(csum_err), .err_cnt(err_cnt)
  );

  dht11_uart_reporter #(.REPORT_CYCLES(50), .ERR_CNT_W(8)) dut_p (
    .clk(clk), .rst(rst),
    .hum_high(p_hh), .hum_low(p_hl), .tem_high(p_th), .tem_low(p_tl), .checksum(p_cs),
    .tx_data(p_tx_data), .tx_valid(p_tx_valid), .tx_ready(p_tx_ready),
    .busy(p_busy), .csum_err(p_csum_err), .err_cnt(p_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_f(input logic [7:0] a, b, c, d, e);
    hh = a; hl = b; th = c; tl = d; cs = e;
  endtask

  task automatic set_pf(input logic [7:0] a, b, c, d, e);
    p_hh = a; p_hl = b; p_th = c; p_tl = d; p_cs = e;
  endtask

  // Collects exp.len() accepted bytes; t0 = cycle of first tx_valid, t_end = cycle of last handshake.
  task automatic recv(input int which, input string exp, input string tag, input bit rnd,
                      output int t0, output int t_end);
    int         k = 0;
    int         n = 0;
    bit         stalled = 1'b0;
    logic [7:0] held = 8'h00;
    logic       v, rdy;
    logic [7:0] d;
    t0 = -1;
    t_end = -1;
    while (k < exp.len() && n < 400) begin
      @(negedge clk);
      n++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (which == 0) tx_ready = rdy;
      else            p_tx_ready = rdy;
      v = (which == 0) ? tx_valid : p_tx_valid;
      d = (which == 0) ? tx_data : p_tx_data;
      if (v && t0 < 0) t0 = cyc;
      if (v && stalled) chk({tag, "_stable"}, d, held);
      if (v && rdy) begin
        chk($sformatf("%s_byte%0d", tag, k), d, exp[k]);
        k++;
        stalled = 1'b0;
        t_end = cyc;
      end else if (v) begin
        held = d;
        stalled = 1'b1;
      end
    end
    chk({tag, "_count"}, k, exp.len());
    if (which == 0) tx_ready = 1'b1;
    else            p_tx_ready = 1'b1;
  endtask

  initial begin
    string m1, m2, m3, m4, m5, m6;
    int t0, t1, t2, t3, t4, e1, e3;
`ifdef DHT11_FRAC_EN
    m1 = "H:45.0 T:23.0\015\012";
    m2 = "H:12.0 T:34.0\015\012";
    m3 = "H:99.0 T:07.0\015\012";
    m4 = "H:45.3 T:23.9\015\012";
    m5 = "H:20.0 T:30.0\015\012";
    m6 = "H:10.0 T:20.0\015\012";
`else
    m1 = "H:45 T:23\015\012";
    m2 = "H:12 T:34\015\012";
    m3 = "H:99 T:07\015\012";
    m4 = "H:45 T:23\015\012";
    m5 = "H:20 T:30\015\012";
    m6 = "H:10 T:20\015\012";
`endif
    rst = 1'b1;
    tx_ready = 1'b1;
    p_tx_ready = 1'b1;
    set_f(0, 0, 0, 0, 0);
    set_pf(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_csum_err", csum_err, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // Good frame: CHECK one cycle after the change, 'H' on the next.
    set_f(45, 0, 23, 0, 68);
    @(negedge clk);
    chk("lat_busy_check", busy, 1);
    chk("lat_no_valid_check", tx_valid, 0);
    @(negedge clk);
    chk("lat_valid", tx_valid, 1);
    chk("lat_first_H", tx_data, 8'h48);
    recv(0, m1.substr(1, m1.len() - 1), "basic", 1'b0, t0, e1);
    @(negedge clk);
    chk("basic_busy_after", busy, 0);
    chk("basic_valid_after", tx_valid, 0);

    // Bad checksum: single csum_err pulse, counter steps, nothing sent.
    set_f(45, 0, 23, 0, 99);
    @(negedge clk);
    chk("bad_pulse", csum_err, 1);
    chk("bad_cnt_before", err_cnt, 0);
    chk("bad_no_valid", tx_valid, 0);
    @(negedge clk);
    chk("bad_pulse_end", csum_err, 0);
    chk("bad_cnt", err_cnt, 1);
    chk("bad_idle", busy, 0);
    repeat (4) @(negedge clk);
    chk("bad_still_no_valid", tx_valid, 0);

    for (int i = 0; i < 300; i++) begin
      set_f(45, 0, 23, 0, (i % 2 == 0) ? 8'd98 : 8'd99);
      repeat (3) @(negedge clk);
    end
    chk("err_saturate", err_cnt, 255);

    recv(0, "", "noop", 1'b0, t0, e1);

    // Random backpressure.
    set_f(12, 0, 34, 0, 46);
    recv(0, m2, "stall", 1'b1, t0, e1);
    @(negedge clk);
    chk("stall_busy_after", busy, 0);

    set_f(120, 0, 7, 0, 127);
    recv(0, m3, "clamp", 1'b0, t0, e1);

    set_f(45, 3, 23, 12, 83);
    recv(0, m4, "frac", 1'b0, t0, e1);

    // Reset while byte 5 is on the bus.
    set_f(20, 0, 30, 0, 50);
    recv(0, m5.substr(0, 4), "pre_rst", 1'b0, t0, e1);
    @(negedge clk);
    chk("pre_rst_valid", tx_valid, 1);
    chk("pre_rst_byte5", tx_data, m5[5]);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_data", tx_data, 0);
    rst = 1'b0;
    recv(0, m5, "post_rst", 1'b0, t0, e1);

    // Periodic instance: fixed 50-cycle period, then an update arriving mid-message.
    set_pf(45, 0, 23, 0, 68);
    recv(1, m1, "p_rep1", 1'b0, t1, e1);
    recv(1, m1, "p_rep2", 1'b0, t2, e1);
    chk("p_period1", t2 - t1, 50);
    recv(1, m1.substr(0, 2), "p_rep3a", 1'b0, t3, e3);
    chk("p_period2", t3 - t2, 50);
    set_pf(10, 0, 20, 0, 30);
    recv(1, m1.substr(3, m1.len() - 1), "p_rep3b", 1'b0, t0, e3);
    recv(1, m6, "p_rep4", 1'b0, t4, e1);
    chk("p_back_to_back", t4 - e3, 3);
    chk("p_no_csum_err", p_err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
